// File: rtl/dmem_pkg.sv
// Shared types, constants and address helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_RESP = 2'd2;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr & 32'(WORD_BYTES - 1)) == 32'd0;
    endfunction

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth_words);
        return addr < 32'(depth_words * WORD_BYTES);
    endfunction

    // Byte address to word number; callers keep only the low index bits they need.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the array has no reset branch so it maps onto RAM macros; contents start unknown.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(WORD_BYTES); i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory port: handshake, wait states,
// error checking, byte-lane stores and a saturating store counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] wr_count
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        we_q, err_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        idle, accept, req_err, enter_resp, commit, read;
    logic        cur_we, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0] ram_rdata;

    assign idle    = (state_q == S_IDLE);
    assign accept  = idle & req_valid;
    assign req_err = !is_aligned(req_addr) || !in_range(req_addr, DEPTH_WORDS);

    // With zero wait states the RAM access happens on the accept edge itself,
    // so the live request is used before it reaches the latches.
    assign cur_we    = idle ? req_we    : we_q;
    assign cur_err   = idle ? req_err   : err_q;
    assign cur_addr  = idle ? req_addr  : addr_q;
    assign cur_wdata = idle ? req_wdata : wdata_q;
    assign cur_be    = idle ? req_be    : be_q;

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (wait_cnt_q == 4'd1));
    assign commit     = enter_resp & cur_we & ~cur_err;
    assign read       = enter_resp & ~cur_we & ~cur_err;
    assign ram_idx    = IDX_W'(word_index(cur_addr));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_count_d = (commit && (wr_count_q != 16'hFFFF)) ? wr_count_q + 16'd1 : wr_count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            wr_count_q <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_count_q <= wr_count_d;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (commit),
        .be   (cur_be),
        .idx  (ram_idx),
        .wdata(cur_wdata),
        .re   (read),
        .rdata(ram_rdata)
    );

    // Response fields are gated by state so they read zero outside RESP and in reset.
    assign req_ready = idle;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : 32'd0;
    assign wr_count  = wr_count_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the MIPS core's data-memory port.
- Accepts load/store requests from the core over a valid/ready handshake, applies a configurable number of wait states, and commits or returns word data.
- Flags misaligned or out-of-range accesses and counts committed stores.
- Sits between the core's dataadr/writedata/memwrite path and the data RAM in top.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the RAM; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait-state cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte-lane enables for stores; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data, valid while rsp_valid is high.
- rsp_err  output  1  access error, valid while rsp_valid is high.
- wr_count  output  16  count of committed stores; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_count=0.
  - The wait counter and latched request registers are cleared.
  - RAM contents are not reset.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. Accept on a rising edge with req_valid=1. Accepting latches we, addr, wdata and be, and loads wait_cnt=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - WAIT: req_ready=0. wait_cnt decrements each cycle. On the edge where wait_cnt==1, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle. Next state is IDLE.
  - No response backpressure: the core must sample the response in the RESP cycle.
- Latency: counting the accept cycle as 0, rsp_valid is high in cycle WAIT_CYCLES+1. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Error check is done at accept. err=1 if addr[1:0]!=0 or addr>=4*DEPTH_WORDS.
- RAM index is addr[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Committed on the edge entering RESP, and only if err=0.
  - Only lanes with be[i]=1 are written.
  - be=4'b0000 is a legal no-op store: rsp_err=0, RAM unchanged, wr_count still increments.
  - wr_count increments by 1 per committed store, saturating, never wrapping. Errored stores do not count.
- Loads:
  - rsp_rdata = RAM[index] registered on the edge entering RESP, so it reflects all previously committed stores.
  - On error, rsp_rdata=0 and rsp_err=1.
  - For stores, rsp_rdata=0.
- rsp_err and rsp_rdata return to 0 when leaving RESP.
- req_valid in WAIT or RESP is ignored; the request is not queued. The core holds req_valid until it sees req_ready.
- Reset mid-operation:
  - Reset in WAIT discards the transaction: no RAM write, no count, no response.
  - Reset in RESP: the store is already committed; rsp_valid drops immediately.
- X/unknown req_valid while in IDLE is a protocol violation. The design is free in that case, but the bench flags it.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the WORD_BYTES=4 constant;
  - the addr-to-index and alignment helper functions.
- One sub-module, dmem_ram: DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte-lane write enable and a registered read port. dmem_responder owns the FSM, the counter and the error logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, wr_count=0 throughout; no accept happens while rst=0.
- Store then load (WAIT_CYCLES=2):
  - store addr=84, wdata=7, be=4'hF, then load addr=84;
  - rsp_valid appears exactly 3 cycles after each accept;
  - load returns rsp_rdata=7, rsp_err=0, wr_count=1.
- Byte lanes:
  - store 32'hAABBCCDD to addr 80, then store 32'h11223344 with be=4'b0101, then load addr 80;
  - expected rsp_rdata=32'hAA22CC44, wr_count=2.
- Errors:
  - store to addr=82 -> rsp_err=1, RAM[20] unchanged, wr_count unchanged;
  - load addr=256 with DEPTH_WORDS=64 -> rsp_err=1, rsp_rdata=0.
- Reset mid-WAIT:
  - store addr=8, wdata=32'h5A5A5A5A; assert rst one cycle after accept;
  - no rsp_valid follows; after release, load addr 8 returns the prior value; wr_count=0.
- WAIT_CYCLES=0 back-to-back:
  - hold req_valid high continuously -> accepts every 2 cycles;
  - rsp_valid in the cycle after each accept;
  - req_ready low exactly during RESP.
